// File: rtl/regfile_write_arbiter_if.sv
// Bundle of two writeback requester channels plus the register-file write port
// they share; master drives requests, slave is the arbiter.
interface regfile_write_arbiter_if #(
    parameter int unsigned DATA_W = 64
);
    logic              hold;
    logic              req0;
    logic              req1;
    logic [4:0]        rd0;
    logic [4:0]        rd1;
    logic [DATA_W-1:0] data0;
    logic [DATA_W-1:0] data1;
    logic              ack0;
    logic              ack1;
    logic [4:0]        rw;
    logic [DATA_W-1:0] bus_w;
    logic              reg_wr;
    logic              conflict;
    logic [31:0]       wr_count;

    modport master (
        output hold, req0, req1, rd0, rd1, data0, data1,
        input  ack0, ack1, rw, bus_w, reg_wr, conflict, wr_count
    );

    modport slave (
        input  hold, req0, req1, rd0, rd1, data0, data1,
        output ack0, ack1, rw, bus_w, reg_wr, conflict, wr_count
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Two-requester round-robin arbiter for a single register-file write port,
// with registered outputs, r31 write suppression and a write counter.
module regfile_write_arbiter #(
    parameter int unsigned DATA_W = 64
) (
    input logic                    clk,
    input logic                    rst,
    regfile_write_arbiter_if.slave bus
);
    localparam logic [4:0] ZERO_REG = 5'd31;

    logic              ptr;
    logic              elig0_c;
    logic              elig1_c;
    logic              grant0_c;
    logic              grant1_c;
    logic              grant_any_c;
    logic              write_c;
    logic              conflict_c;
    logic [4:0]        grant_rd_c;
    logic [DATA_W-1:0] grant_data_c;

    // Grant selection: a requester is blocked during its own ack cycle, and
    // the pointer only breaks ties when both are eligible.
    always_comb begin
        elig0_c      = 1'b0;
        elig1_c      = 1'b0;
        grant0_c     = 1'b0;
        grant1_c     = 1'b0;
        grant_any_c  = 1'b0;
        write_c      = 1'b0;
        conflict_c   = 1'b0;
        grant_rd_c   = bus.rd0;
        grant_data_c = bus.data0;

        elig0_c  = bus.req0 & ~bus.ack0 & ~bus.hold;
        elig1_c  = bus.req1 & ~bus.ack1 & ~bus.hold;
        grant0_c = elig0_c & (~elig1_c | ~ptr);
        grant1_c = elig1_c & (~elig0_c | ptr);
        grant_any_c = grant0_c | grant1_c;

        if (grant1_c) begin
            grant_rd_c   = bus.rd1;
            grant_data_c = bus.data1;
        end

        write_c    = grant_any_c && (grant_rd_c != ZERO_REG);
        conflict_c = elig0_c && elig1_c && (bus.rd0 == bus.rd1) && (bus.rd0 != ZERO_REG);
    end

    // Output and pointer registers; rw/bus_w hold when nothing is granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr          <= 1'b0;
            bus.ack0     <= 1'b0;
            bus.ack1     <= 1'b0;
            bus.rw       <= 5'd0;
            bus.bus_w    <= '0;
            bus.reg_wr   <= 1'b0;
            bus.conflict <= 1'b0;
            bus.wr_count <= 32'd0;
        end else begin
            bus.ack0     <= grant0_c;
            bus.ack1     <= grant1_c;
            bus.reg_wr   <= write_c;
            bus.conflict <= conflict_c;
            bus.wr_count <= bus.wr_count + 32'(write_c);
            if (grant_any_c) begin
                ptr       <= grant0_c;
                bus.rw    <= grant_rd_c;
                bus.bus_w <= grant_data_c;
            end
        end
    end
endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, meaning the width of the write data path and of BusW.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset: Clk input 1 is the clock (posedge); Reset input 1 is the reset, asynchronous and active-high.
REQ-003 The block SHALL have Hold, input, 1 bit: freezes arbitration when high.
REQ-004 The block SHALL have Req0 and Req1, inputs, 1 bit each: write requests from requester 0 (ALU writeback) and requester 1 (load/multicycle unit).
REQ-005 The block SHALL have Rd0 and Rd1, inputs, 5 bits each: destination register index per requester.
REQ-006 The block SHALL have Data0 and Data1, inputs, DATA_W bits each: write data per requester.
REQ-007 The block SHALL have Ack0 and Ack1, outputs, 1 bit each: a one-cycle pulse marking that the request has completed.
REQ-008 The block SHALL have RW, output, 5 bits; BusW, output, DATA_W bits; and RegWr, output, 1 bit: these drive the register file write port.
REQ-009 The block SHALL have Conflict, output, 1 bit: a pulse marking that both requesters targeted the same writable register in the granted cycle.
REQ-010 The block SHALL have WrCount, output, 32 bits: the number of register-file writes issued.

Function
REQ-011 Eligibility: requester i SHALL be eligible in a cycle when Req_i=1, Ack_i=0 and Hold=0.
REQ-012 The block SHALL grant at most one eligible requester per posedge Clk.
REQ-013 Priority: a pointer PTR (1 bit) SHALL decide priority. If both requesters are eligible, the requester equal to PTR wins. If only one is eligible, that requester wins.
REQ-014 After any grant to requester i, PTR SHALL be set to the other requester; with no grant, PTR SHALL hold.
REQ-015 Latency: the grant SHALL register Rd_i into RW and Data_i into BusW at the granting posedge, with outputs valid for exactly the following cycle (latency 1).
REQ-016 RegWr SHALL be 1 in the cycle after a grant, except when the granted Rd is 31.
REQ-017 Register 31 is the hardwired zero: a grant with Rd=31 SHALL drive RegWr=0, SHALL still pulse Ack_i, and SHALL NOT increment WrCount.
REQ-018 Ack_i SHALL be asserted for exactly the one cycle following the grant to i, coincident with the RW/BusW/RegWr it caused.
REQ-019 Handshake: each requester holds Req_i, Rd_i and Data_i stable until it sees Ack_i. It may drop Req_i, or present a new request, in the cycle after Ack_i.
REQ-020 With no grant, RegWr, Ack0 and Ack1 SHALL be 0. RW and BusW SHALL hold their previous values.
REQ-021 Output timing: all outputs SHALL be registered, changing only on posedge Clk or Reset.
REQ-022 The register file samples its write port on negedge Clk, mid-cycle of the output-valid cycle.
REQ-023 Conflict SHALL pulse 1, coincident with Ack, when both requesters were eligible, Rd0==Rd1 and Rd0!=31 at the granting edge. The loser is served later, so the later data wins in the register file.
REQ-024 WrCount SHALL increment by 1 for every cycle with RegWr=1, wrapping from 0xFFFFFFFF to 0.
REQ-025 Hold=1 SHALL block new grants. A grant made at the edge before Hold rose SHALL still complete (Ack/RegWr) normally.
REQ-026 Starvation: with both requesters continuously requesting, grants SHALL alternate, so neither waits more than 3 cycles from assertion to Ack.

Reset
REQ-027 While Reset=1, the block SHALL immediately (asynchronously) drive the following outputs and state to 0: RW, BusW, RegWr, Ack0, Ack1, Conflict, WrCount, PTR.
REQ-028 A pending request SHALL be discarded by reset and re-arbitrated only if still asserted after reset deasserts.
REQ-029 After reset deassertion, the first eligible request SHALL be granted at the next posedge Clk.
REQ-030 A reset asserted in an output-valid cycle SHALL force RegWr=0 before the negedge, so no write occurs.

Verification
REQ-031 Directed scenario, single requester: Req0=1, Rd0=5, Data0=0xAA -> next cycle RW=5, BusW=0xAA, RegWr=1, Ack0=1, WrCount=1.
REQ-032 Directed scenario, both requesting after reset: Req0 (Rd=3) and Req1 (Rd=4) both high -> requester 0 acked first, requester 1 acked the cycle after, and RegWr=1 in both cycles.
REQ-033 Directed scenario, zero-register write: Req1=1, Rd1=31, Data1=0x1234 -> Ack1=1, RegWr=0, WrCount unchanged.
REQ-034 Directed scenario, same destination: Req0 and Req1 both with Rd=7 -> Conflict=1 with the first Ack, both writes issued, and the second write's data is final in register 7.
REQ-035 Directed scenario, Hold: Hold=1 for 3 cycles with Req0=1 -> no Ack and RegWr=0 for 3 cycles, then Ack0 one cycle after Hold falls.
REQ-036 Directed scenario, reset mid-operation: Reset pulsed in the Ack cycle -> Ack/RegWr forced to 0, WrCount=0, no negedge write.
